// File: rtl/stream_pkg.sv
// Shared stream-port definitions.
// Flag bit positions and widths for the master flags (downstream-going,
// {A,F,L,V}) and slave flags (upstream-going, {reserved,BSY}) used by every
// streaming block.
package stream_pkg;

  localparam int MF_W   = 4;
  localparam int SF_W   = 2;

  localparam int MF_V   = 0;
  localparam int MF_L   = 1;
  localparam int MF_F   = 2;
  localparam int MF_A   = 3;

  localparam int SF_BSY = 0;

endpackage

// File: rtl/iir4_mac.sv
// Combinational 7-term multiply/accumulate for the 3rd-order DF-I IIR.
//   y = b0*x0 + b1*x1 + b2*x2 + b3*x3 - a1*y1 - a2*y2 - a3*y3   (modulo 2^W)
// Ports:
//   b0..b3  in  W  feed-forward coefficients (signed)
//   a1..a3  in  W  feedback coefficients (signed)
//   x0..x3  in  W  x[n], x[n-1], x[n-2], x[n-3]
//   y1..y3  in  W  y[n-1], y[n-2], y[n-3]
//   y       out W  y[n]
module iir4_mac
  import stream_pkg::*;
#(
  parameter int W = 16
) (
  input  logic signed [W-1:0] b0,
  input  logic signed [W-1:0] b1,
  input  logic signed [W-1:0] b2,
  input  logic signed [W-1:0] b3,
  input  logic signed [W-1:0] a1,
  input  logic signed [W-1:0] a2,
  input  logic signed [W-1:0] a3,
  input  logic signed [W-1:0] x0,
  input  logic signed [W-1:0] x1,
  input  logic signed [W-1:0] x2,
  input  logic signed [W-1:0] x3,
  input  logic signed [W-1:0] y1,
  input  logic signed [W-1:0] y2,
  input  logic signed [W-1:0] y3,
  output logic signed [W-1:0] y
);

  // Full-precision product reduced to its W LSBs; the filter deliberately
  // wraps instead of saturating or rounding.
  function automatic logic signed [W-1:0] mul_wrap(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
    logic signed [2*W-1:0] full;
    full = a * b;
    return $signed(full[W-1:0]);
  endfunction

  logic signed [W-1:0] ff0, ff1, ff2, ff3;
  logic signed [W-1:0] fb1, fb2, fb3;

  always_comb begin
    ff0 = mul_wrap(b0, x0);
    ff1 = mul_wrap(b1, x1);
    ff2 = mul_wrap(b2, x2);
    ff3 = mul_wrap(b3, x3);
    fb1 = mul_wrap(a1, y1);
    fb2 = mul_wrap(a2, y2);
    fb3 = mul_wrap(a3, y3);
    // W-bit context: the sum wraps modulo 2^W.
    y   = ff0 + ff1 + ff2 + ff3 - fb1 - fb2 - fb3;
  end

endmodule

// File: rtl/iir4_stream.sv
// Streaming 4-tap (3rd-order) direct-form-I IIR filter.
// One sample in, one filtered sample out, latency 1 clock. The output word
// is held while downstream is busy; the upstream sees that as BSY.
// Ports:
//   clk           in   1      clock, rising edge
//   rst_n         in   1      asynchronous active-low reset
//   B0..B3        in   W      feed-forward coefficients (signed, static)
//   A1..A3        in   W      feedback coefficients (signed, static)
//   x_in_d0       in   W      input sample
//   x_in_mflags   in   MF_W   input flags {A,F,L,V}
//   x_in_sflags   out  SF_W   to upstream: [0] BSY, [1] reserved (0)
//   y_out_d0      out  W      filtered sample
//   y_out_mflags  out  MF_W   output flags, aligned with y_out_d0
//   y_out_sflags  in   SF_W   from downstream: [0] BSY, [1] ignored
module iir4_stream
  import stream_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] B0,
  input  logic signed [W-1:0] B1,
  input  logic signed [W-1:0] B2,
  input  logic signed [W-1:0] B3,
  input  logic signed [W-1:0] A1,
  input  logic signed [W-1:0] A2,
  input  logic signed [W-1:0] A3,
  input  logic signed [W-1:0] x_in_d0,
  input  logic [MF_W-1:0]     x_in_mflags,
  output logic [SF_W-1:0]     x_in_sflags,
  output logic signed [W-1:0] y_out_d0,
  output logic [MF_W-1:0]     y_out_mflags,
  input  logic [SF_W-1:0]     y_out_sflags
);

  logic signed [W-1:0] x_d1, x_d2, x_d3;
  logic signed [W-1:0] y_d1, y_d2, y_d3;
  logic signed [W-1:0] y_new;
  logic                stall;
  logic                accept;
  logic                unused_sflags;

  // Only a word actually being presented can be stalled; BSY against an
  // empty output slot lets the stream keep flowing.
  assign stall  = y_out_sflags[SF_BSY] & y_out_mflags[MF_V];
  assign accept = x_in_mflags[MF_V] & ~stall;

  assign x_in_sflags   = {1'b0, stall};
  assign unused_sflags = y_out_sflags[1];

  iir4_mac #(.W(W)) u_mac (
    .b0 (B0),
    .b1 (B1),
    .b2 (B2),
    .b3 (B3),
    .a1 (A1),
    .a2 (A2),
    .a3 (A3),
    .x0 (x_in_d0),
    .x1 (x_d1),
    .x2 (x_d2),
    .x3 (x_d3),
    .y1 (y_d1),
    .y2 (y_d2),
    .y3 (y_d3),
    .y  (y_new)
  );

  // ---- stage boundary: delay lines and output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_d1         <= '0;
      x_d2         <= '0;
      x_d3         <= '0;
      y_d1         <= '0;
      y_d2         <= '0;
      y_d3         <= '0;
      y_out_d0     <= '0;
      y_out_mflags <= '0;
    end else if (accept) begin
      x_d1         <= x_in_d0;
      x_d2         <= x_d1;
      x_d3         <= x_d2;
      y_d1         <= y_new;
      y_d2         <= y_d1;
      y_d3         <= y_d2;
      y_out_d0     <= y_new;
      y_out_mflags <= x_in_mflags;
    end else if (!stall) begin
      // Idle cycle: retire the presented word, keep data and history.
      y_out_mflags[MF_V] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iir4_stream.sv
module tb_iir4_stream;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic signed [W-1:0] B0, B1, B2, B3, A1, A2, A3;
  logic signed [W-1:0] x_in_d0;
  logic [3:0]          x_in_mflags;
  logic [1:0]          x_in_sflags;
  logic signed [W-1:0] y_out_d0;
  logic [3:0]          y_out_mflags;
  logic [1:0]          y_out_sflags;

  int checks = 0;
  int errors = 0;

  // Reference model state (unstalled filter history)
  longint mx [0:3];
  longint my [1:3];
  longint cb [0:3];
  longint ca [1:3];

  always #5 clk = ~clk;

  iir4_stream #(.W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .B0           (B0),
    .B1           (B1),
    .B2           (B2),
    .B3           (B3),
    .A1           (A1),
    .A2           (A2),
    .A3           (A3),
    .x_in_d0      (x_in_d0),
    .x_in_mflags  (x_in_mflags),
    .x_in_sflags  (x_in_sflags),
    .y_out_d0     (y_out_d0),
    .y_out_mflags (y_out_mflags),
    .y_out_sflags (y_out_sflags)
  );

  function automatic longint sx16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mx[i] = 0;
    for (int k = 1; k < 4; k++) my[k] = 0;
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] x);
    longint acc;
    logic [63:0] acc_bits;
    logic [15:0] res;
    mx[3] = mx[2]; mx[2] = mx[1]; mx[1] = mx[0]; mx[0] = sx16(x);
    acc = 0;
    for (int i = 0; i < 4; i++) acc += cb[i] * mx[i];
    for (int k = 1; k < 4; k++) acc -= ca[k] * my[k];
    acc_bits = acc;
    res = acc_bits[15:0];
    my[3] = my[2]; my[2] = my[1]; my[1] = sx16(res);
    return res;
  endfunction

  task automatic set_coeffs(input int b0, input int b1, input int b2, input int b3,
                            input int a1, input int a2, input int a3);
    B0 = 16'(b0); B1 = 16'(b1); B2 = 16'(b2); B3 = 16'(b3);
    A1 = 16'(a1); A2 = 16'(a2); A3 = 16'(a3);
    cb[0] = b0; cb[1] = b1; cb[2] = b2; cb[3] = b3;
    ca[1] = a1; ca[2] = a2; ca[3] = a3;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    x_in_mflags  = 4'b0000;
    x_in_d0      = '0;
    y_out_sflags = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
  endtask

  // Drive one input word, clock once, leave #1 after the edge for sampling.
  task automatic drive(input logic [15:0] x, input logic [3:0] fl);
    x_in_d0     = x;
    x_in_mflags = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    x_in_mflags  = 4'b1111;
    x_in_d0      = 16'h1234;
    y_out_sflags = 2'b11;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (y_out_mflags !== 4'b0000) begin
      errors++; $display("FAIL reset_mflags: got %b want %b", y_out_mflags, 4'b0000);
    end
    checks++;
    if (y_out_d0 !== 16'h0000) begin
      errors++; $display("FAIL reset_d0: got %h want %h", y_out_d0, 16'h0000);
    end
    checks++;
    if (x_in_sflags !== 2'b00) begin
      errors++; $display("FAIL reset_sflags: got %b want %b", x_in_sflags, 2'b00);
    end
    rst_n = 1'b1;
    x_in_mflags = 4'b0000;
    y_out_sflags = 2'b00;
    model_clear();
  endtask

  task automatic test_impulse();
    logic [15:0] xin [4];
    logic [15:0] yexp [4];
    xin  = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    yexp = '{16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF};
    do_reset();
    set_coeffs(1, 1, 1, 1, 2, 2, 2);
    for (int i = 0; i < 4; i++) begin
      drive(xin[i], 4'b0001);
      checks++;
      if (y_out_d0 !== yexp[i]) begin
        errors++; $display("FAIL impulse_y[%0d]: got %h want %h", i, y_out_d0, yexp[i]);
      end
      checks++;
      if (y_out_mflags !== 4'b0001) begin
        errors++; $display("FAIL impulse_v[%0d]: got %b want %b", i, y_out_mflags, 4'b0001);
      end
    end
  endtask

  task automatic test_step();
    logic [15:0] yexp [4];
    yexp = '{16'h0001, 16'h0000, 16'h0001, 16'h0000};
    do_reset();
    set_coeffs(1, 1, 1, 1, 2, 2, 2);
    for (int i = 0; i < 4; i++) begin
      drive(16'h0001, 4'b0001);
      checks++;
      if (y_out_d0 !== yexp[i]) begin
        errors++; $display("FAIL step_y[%0d]: got %h want %h", i, y_out_d0, yexp[i]);
      end
    end
  endtask

  task automatic test_flags();
    do_reset();
    set_coeffs(1, 1, 1, 1, 2, 2, 2);
    drive(16'h0001, 4'b0101);
    checks++;
    if (y_out_mflags !== 4'b0101) begin
      errors++; $display("FAIL flags_pass: got %b want %b", y_out_mflags, 4'b0101);
    end
    checks++;
    if (y_out_d0 !== 16'h0001) begin
      errors++; $display("FAIL flags_y0: got %h want %h", y_out_d0, 16'h0001);
    end
    // V=0 word: ignored, output valid drops, data held
    drive(16'h0007, 4'b0000);
    checks++;
    if (y_out_mflags[0] !== 1'b0) begin
      errors++; $display("FAIL flags_idle_v: got %b want %b", y_out_mflags[0], 1'b0);
    end
    checks++;
    if (y_out_d0 !== 16'h0001) begin
      errors++; $display("FAIL flags_idle_hold: got %h want %h", y_out_d0, 16'h0001);
    end
    // History untouched by the V=0 word: continues the impulse response
    drive(16'h0000, 4'b1011);
    checks++;
    if (y_out_d0 !== 16'hFFFF) begin
      errors++; $display("FAIL flags_hist: got %h want %h", y_out_d0, 16'hFFFF);
    end
    checks++;
    if (y_out_mflags !== 4'b1011) begin
      errors++; $display("FAIL flags_alv: got %b want %b", y_out_mflags, 4'b1011);
    end
    // F mid-stream must not clear history
    drive(16'h0000, 4'b0101);
    checks++;
    if (y_out_d0 !== 16'h0001) begin
      errors++; $display("FAIL flags_f_noclear: got %h want %h", y_out_d0, 16'h0001);
    end
  endtask

  task automatic test_reset_midstream();
    drive(16'h0003, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (y_out_d0 !== 16'h0000 || y_out_mflags !== 4'b0000) begin
      errors++; $display("FAIL async_reset: got %h/%b want 0000/0000", y_out_d0, y_out_mflags);
    end
    x_in_mflags = 4'b0000;
    @(posedge clk);
    #1 rst_n = 1'b1;
    // Same coefficients: history gone, so a unit input gives y=1
    drive(16'h0001, 4'b0001);
    checks++;
    if (y_out_d0 !== 16'h0001) begin
      errors++; $display("FAIL reset_hist_clear: got %h want %h", y_out_d0, 16'h0001);
    end
  endtask

  task automatic test_back_to_back_stall();
    int          idx;
    logic        exp_valid;
    logic        exp_stall;
    logic        bsy;
    logic [15:0] exp_y;
    logic [15:0] xv;
    do_reset();
    set_coeffs(2, -3, 5, 1, 1, -2, 3);
    idx = 0;
    exp_valid = 1'b0;
    exp_y = 16'h0000;
    for (int c = 0; c < 48; c++) begin
      bsy = ((c % 12) == 5) || ((c % 12) == 6);
      xv  = 16'((idx * 37) % 23 - 11);
      y_out_sflags = {1'b0, bsy};
      x_in_d0      = xv;
      x_in_mflags  = 4'b0001;
      exp_stall    = bsy & exp_valid;
      #1;
      checks++;
      if (x_in_sflags !== {1'b0, exp_stall}) begin
        errors++; $display("FAIL bp_sflags[%0d]: got %b want %b", c, x_in_sflags, {1'b0, exp_stall});
      end
      @(posedge clk);
      if (!exp_stall) begin
        exp_y = model_step(xv);
        exp_valid = 1'b1;
        idx++;
      end
      #1;
      checks++;
      if (y_out_d0 !== exp_y || y_out_mflags[0] !== exp_valid) begin
        errors++; $display("FAIL bp_out[%0d]: got %h v%b want %h v%b", c, y_out_d0, y_out_mflags[0], exp_y, exp_valid);
      end
    end
    y_out_sflags = 2'b00;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_y;
    logic [15:0] xv;
    do_reset();
    set_coeffs(3, -5, 7, 11, -2, 3, -1);
    for (int n = 0; n < 1000; n++) begin
      xv = 16'((n % 15) + 1);
      exp_y = model_step(xv);
      drive(xv, 4'b0001);
      checks++;
      if (y_out_d0 !== exp_y) begin
        errors++; $display("FAIL wrap_y[%0d]: got %h want %h", n, y_out_d0, exp_y);
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    x_in_d0      = '0;
    x_in_mflags  = '0;
    y_out_sflags = '0;
    set_coeffs(1, 1, 1, 1, 2, 2, 2);
    test_reset();
    test_impulse();
    test_step();
    test_flags();
    test_reset_midstream();
    test_back_to_back_stall();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
